imem_program_loader: RTL and testbench

- Consumes 32-bit words from the upstream serial-bit assembler (`word_in` / `word_valid`) and writes them sequentially into instruction memory from word address 0.
- Holds the RISC-V core in reset (`cpu_hold`) until a complete program has been loaded and terminated by an end-marker word.
- Sits between the UART/ASCII-to-bits path and the imem write port.

---
 rtl/imem_program_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_program_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader
// Takes assembled 32-bit words from the serial-bit path and writes them into
// instruction memory starting at word address 0. The core is held in reset
// until the program has been closed with END_WORD.
// Optional build macro: LOADER_CHECKSUM_EN adds a CHECK state. In that state
// the word that follows END_WORD must equal the 32-bit running sum of all
// written words.
module imem_program_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          MAX_WORDS  = 1024,
    parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           word_in,
    input  logic                  word_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   word_count
);

    // word_count is one bit wider than the address, so the value MAX_WORDS
    // itself can be represented when the memory is full.
    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DONE  = 3'd2,
        ERROR = 3'd3,
        CHECK = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DONE  = 3'd2,
        ERROR = 3'd3
    } state_t;
`endif

    state_t                state_q,      state_d;
    logic                  imem_we_q,    imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  load_done_q,  load_done_d;
    logic                  load_error_q, load_error_d;
    logic                  cpu_hold_q,   cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]           sum_q,        sum_d;
`endif

    logic is_end_word;
    logic room_left;

    assign is_end_word = (word_in == END_WORD);
    assign room_left   = (word_count_q < MAX_CNT);

    // Next-state and next-output logic; every output is computed here and registered.
    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        cpu_hold_d   = cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            // A strobe that arrives in the same cycle as start is dropped.
            // The session only opens at the start edge.
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    cpu_hold_d   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end

            LOAD: begin
                if (word_valid) begin
                    if (is_end_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d     = CHECK;
`else
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
`endif
                    end else if (room_left) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = word_in;
                        word_count_d = word_count_q + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                        sum_d        = sum_q + word_in;
`endif
                    end else begin
                        // The memory is already full, so the extra word is dropped and flagged.
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            // The checksum word is compared here and is not written to memory.
            CHECK: begin
                if (word_valid) begin
                    if (word_in == sum_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
`endif

            DONE, ERROR: begin
                if (start) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    cpu_hold_d   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end

            default: begin
                state_d    = IDLE;
                cpu_hold_d = 1'b1;
            end
        endcase
    end

    // State and output registers. Reset is synchronous and active low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            cpu_hold_q   <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign word_count = word_count_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader. The stimulus pushes every expected imem
// write into a queue, tagged with the address, the data and the cycle it must
// appear in. A monitor pops and compares each write it observes. Level outputs
// are checked directly against hand-computed constants.
module tb_imem_program_loader;

    localparam int AW = 10;
    localparam int MW = 4;
    localparam logic [31:0] END_W = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   word_in;
    logic          word_valid;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   word_count;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    imem_program_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW), .END_WORD(END_W)) dut (
        .clk(clk), .rst(rst), .start(start), .word_in(word_in),
        .word_valid(word_valid), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // The monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h at cycle %0d, expected no write",
                         imem_addr, imem_wdata, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (imem_addr !== e.addr[AW-1:0] || imem_wdata !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h cycle %0d, expected addr %0h data %0h cycle %0d",
                             imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
                end else begin
                    $display("ok   write addr %0h data %0h cycle %0d", imem_addr, imem_wdata, cyc);
                end
            end
        end
    end

    // Present one word for one cycle. If a write is expected, queue it for
    // the cycle after the sampling edge.
    task automatic strobe(input logic [31:0] w, input bit wr, input int unsigned a);
        word_in    = w;
        word_valid = 1'b1;
        if (wr) exp_q.push_back('{addr: a, data: w, cyc: cyc + 1});
        @(posedge clk); #1;
        word_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    {31'd0, imem_we},    32'd0);
        check({tag, "_addr"},  {22'd0, imem_addr},  32'd0);
        check({tag, "_wdata"}, imem_wdata,          32'd0);
        check({tag, "_count"}, {21'd0, word_count}, 32'd0);
        check({tag, "_done"},  {31'd0, load_done},  32'd0);
        check({tag, "_err"},   {31'd0, load_error}, 32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold},   32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; word_in = '0; word_valid = 1'b0;
        idle(2);
        check_reset_values("reset");
        rst = 1'b1;
        idle(1);

        // Words are ignored in IDLE, including one in the same cycle as start.
        strobe(32'h0000_0013, 0, 0);
        start = 1'b1; word_in = 32'h0000_0055; word_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; word_valid = 1'b0;
        idle(2);
        check("pre_start_count", {21'd0, word_count}, 32'd0);
        check("pre_start_hold",  {31'd0, cpu_hold},   32'd1);

        // An empty program goes straight to DONE without any write.
        strobe(END_W, 0, 0);
        idle(1);
        check("empty_done",  {31'd0, load_done},  32'd1);
        check("empty_hold",  {31'd0, cpu_hold},   32'd0);
        check("empty_count", {21'd0, word_count}, 32'd0);

        // Load a two-word program. A start pulse in the middle is ignored.
        pulse_start();
        check("restart_done", {31'd0, load_done}, 32'd0);
        check("restart_hold", {31'd0, cpu_hold},  32'd1);
        strobe(32'h0000_0093, 1, 0);
        pulse_start();
        check("start_in_load_count", {21'd0, word_count}, 32'd1);
        strobe(32'h0010_0113, 1, 1);
        strobe(END_W, 0, 0);
        idle(1);
        check("prog_count", {21'd0, word_count}, 32'd2);
        check("prog_done",  {31'd0, load_done},  32'd1);
        check("prog_err",   {31'd0, load_error}, 32'd0);
        check("prog_hold",  {31'd0, cpu_hold},   32'd0);
        check("prog_addr_hold",  {22'd0, imem_addr}, 32'd1);
        check("prog_wdata_hold", imem_wdata,         32'h0010_0113);
        strobe(32'h0000_00AA, 0, 0);
        check("done_ignores_word", {21'd0, word_count}, 32'd2);

        // Overflow: four words fit, and the fifth word is an error.
        pulse_start();
        for (int i = 0; i < 4; i++) strobe(32'hA000_0000 + i, 1, i);
        strobe(32'hA000_0004, 0, 0);
        idle(1);
        check("ovf_err",   {31'd0, load_error}, 32'd1);
        check("ovf_hold",  {31'd0, cpu_hold},   32'd1);
        check("ovf_done",  {31'd0, load_done},  32'd0);
        check("ovf_count", {21'd0, word_count}, 32'd4);
        strobe(END_W, 0, 0);
        check("err_ignores_word", {31'd0, load_error}, 32'd1);
        pulse_start();
        check("ovf_restart_err",   {31'd0, load_error}, 32'd0);
        check("ovf_restart_count", {21'd0, word_count}, 32'd0);
        check("ovf_restart_hold",  {31'd0, cpu_hold},   32'd1);

        // Three back-to-back words give three consecutive write cycles.
        strobe(32'h1111_1111, 1, 0);
        strobe(32'h2222_2222, 1, 1);
        strobe(32'h3333_3333, 1, 2);
        strobe(END_W, 0, 0);
        idle(1);
        check("burst_count", {21'd0, word_count}, 32'd3);
        check("burst_done",  {31'd0, load_done},  32'd1);

        // A reset in the middle of LOAD abandons the session.
        pulse_start();
        strobe(32'h4444_4444, 1, 0);
        strobe(32'h5555_5555, 1, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_values("midreset");
        rst = 1'b1;
        strobe(32'h6666_6666, 0, 0);
        idle(1);
        check("post_reset_idle_count", {21'd0, word_count}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum matches: 1 + 2 = 3.
        pulse_start();
        strobe(32'd1, 1, 0);
        strobe(32'd2, 1, 1);
        strobe(END_W, 0, 0);
        check("check_wait_done", {31'd0, load_done}, 32'd0);
        check("check_wait_hold", {31'd0, cpu_hold},  32'd1);
        strobe(32'd3, 0, 0);
        check("csum_ok_done", {31'd0, load_done}, 32'd1);
        check("csum_ok_hold", {31'd0, cpu_hold},  32'd0);
        // Checksum mismatch. A start pulse during CHECK is ignored.
        pulse_start();
        strobe(32'd1, 1, 0);
        strobe(32'd2, 1, 1);
        strobe(END_W, 0, 0);
        pulse_start();
        check("start_in_check_count", {21'd0, word_count}, 32'd2);
        strobe(32'd4, 0, 0);
        check("csum_bad_err",  {31'd0, load_error}, 32'd1);
        check("csum_bad_hold", {31'd0, cpu_hold},   32'd1);
`endif

        idle(3);
        check("pending_writes", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
